// File: rtl/minilab0_sw_led_core.sv
// minilab0_sw_led_core: two-phase (fetch/execute) sequencer that runs a fixed
// ROM program copying the slide switches to the LEDs through I/O ports.
module minilab0_sw_led_core #(
  parameter int          ROM_DEPTH = 16,
  parameter logic [7:0]  SW_PORT   = 8'h01,
  parameter logic [7:0]  LED_PORT  = 8'h00
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  localparam int PC_W   = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int DATA_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_IN   = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  // Fixed program: IN r1,SW_PORT / OUT r1,LED_PORT / JMP 0, rest NOP.
  function automatic logic [DATA_W-1:0] rom_word(input logic [PC_W-1:0] addr);
    logic [DATA_W-1:0] w;
    w = {OP_NOP, 12'h000};
    if (addr == PC_W'(0))
      w = {OP_IN, 2'd1, 2'b00, SW_PORT};
    else if (addr == PC_W'(1))
      w = {OP_OUT, 2'd1, 2'b00, LED_PORT};
    else if (addr == PC_W'(2))
      w = {OP_JMP, 2'd0, 2'b00, 8'h00};
    return w;
  endfunction

  // Sequential increment that wraps at ROM_DEPTH even when it is not a power of two.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    logic [PC_W-1:0] n;
    if (pc == PC_W'(ROM_DEPTH - 1))
      n = '0;
    else
      n = pc + PC_W'(1);
    return n;
  endfunction

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];
  logic [9:0]        ledr_q, ledr_d;

  logic [3:0] opcode;
  logic [1:0] rsel;
  logic [7:0] imm8;

  assign opcode = ir_q[15:12];
  assign rsel   = ir_q[11:10];
  assign imm8   = ir_q[7:0];
  assign LEDR   = ledr_q;

  // Next-state logic: FETCH loads IR and advances PC, EXEC applies the instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    ledr_d  = ledr_q;
    unique case (state_q)
      FETCH: begin
        ir_d    = rom_word(pc_q);
        pc_d    = pc_next(pc_q);
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (opcode)
          OP_LDI: regs_d[rsel] = {8'h00, imm8};
          OP_IN: begin
            if (imm8 == SW_PORT)
              regs_d[rsel] = {6'b000000, SW};
            else
              regs_d[rsel] = '0;
          end
          OP_OUT: begin
            // Writes to unmapped ports are silently dropped.
            if (imm8 == LED_PORT)
              ledr_d = regs_q[rsel][9:0];
          end
          OP_JMP:  pc_d    = PC_W'(imm8);
          OP_HALT: state_d = EXEC;  // parks in EXEC until reset
          default: ;
        endcase
      end
      default: state_d = FETCH;
    endcase
  end

  // State register; reset wins over any instruction in flight.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      regs_q  <= '{default: '0};
      ledr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      regs_q  <= regs_d;
      ledr_q  <= ledr_d;
    end
  end

endmodule

// File: tb/tb_minilab0_sw_led_core.sv
// Self-checking bench for minilab0_sw_led_core: vector table, directed
// corner cases, and randomized traffic against a program-schedule model.
module tb_minilab0_sw_led_core;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] SW  = 10'h000;
  logic [9:0] LEDR;

  minilab0_sw_led_core dut (
    .clk  (clk),
    .RST  (RST),
    .SW   (SW),
    .LEDR (LEDR)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the program is a 6-edge loop after reset release;
  // SW is captured on loop edge 2 and shown on the LEDs on loop edge 4.
  int         m_edge = 0;
  logic [9:0] m_r1   = 10'h000;
  logic [9:0] m_led  = 10'h000;

  typedef struct {
    logic       rst;
    logic [9:0] sw;
    logic [9:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (RST) begin
      m_edge = 0;
      m_r1   = 10'h000;
      m_led  = 10'h000;
    end else begin
      m_edge++;
      if (m_edge % 6 == 2) m_r1 = SW;
      else if (m_edge % 6 == 4) m_led = m_r1;
    end
    #1;
  endtask

  initial begin
    logic [9:0] rsw;
    logic       seen;
    int         extra;

    // ---------- table: reset with SW=3FF, release with SW=2A5 ----------
    for (int i = 0; i < 2; i++) vt.push_back('{rst: 1'b1, sw: 10'h3FF, exp: 10'h000});
    for (int e = 1; e <= 15; e++)
      vt.push_back('{rst: 1'b0, sw: 10'h2A5, exp: (e >= 4) ? 10'h2A5 : 10'h000});

    #1;
    foreach (vt[i]) begin
      RST = vt[i].rst;
      SW  = vt[i].sw;
      step();
      check($sformatf("table[%0d] LEDR", i), 16'(LEDR), 16'(vt[i].exp));
      if (i == 1) begin
        check("reset pc", 16'(dut.pc_q), 16'h0000);
        check("reset state", 16'(dut.state_q), 16'h0000);
        check("reset r1", dut.regs_q[1], 16'h0000);
      end
    end

    // ---------- ten reset/random-SW loops ----------
    for (int k = 0; k < 10; k++) begin
      RST = 1'b1;
      step();
      SW  = 10'($urandom);
      RST = 1'b0;
      repeat (15) step();
      check($sformatf("loop%0d LEDR==SW", k), 16'(LEDR), 16'(SW));
      check($sformatf("loop%0d model", k), 16'(LEDR), 16'(m_led));
    end

    // ---------- live tracking 001 -> 200 ----------
    RST = 1'b1;
    step();
    SW  = 10'h001;
    RST = 1'b0;
    repeat (15) step();
    check("live steady 001", 16'(LEDR), 16'h0001);
    extra = $urandom_range(0, 5);
    repeat (extra) step();
    SW   = 10'h200;
    seen = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (LEDR != 10'h001 && LEDR != 10'h200) begin
        n_bad++;
        $display("FAIL live intermediate: got %0h required 001 or 200", LEDR);
      end
      n_cmp++;
      if (LEDR == 10'h200) seen = 1'b1;
    end
    check("live reached 200 in 8", 16'(seen), 16'h0001);

    // ---------- reset at the EXEC edge of OUT ----------
    RST = 1'b1;
    step();
    SW  = 10'h0F0;
    RST = 1'b0;
    repeat (4) step();                    // edge 4: OUT lands
    check("midrst pre 0F0", 16'(LEDR), 16'h00F0);
    SW = 10'h155;
    repeat (5) step();                    // edges 5..9, IN at edge 8 takes 155
    check("midrst r1 155", dut.regs_q[1], 16'h0155);
    check("midrst hold 0F0", 16'(LEDR), 16'h00F0);
    RST = 1'b1;
    step();                               // edge 10 would have been OUT
    check("midrst LEDR cleared", 16'(LEDR), 16'h0000);
    check("midrst pc", 16'(dut.pc_q), 16'h0000);
    check("midrst state", 16'(dut.state_q), 16'h0000);
    RST = 1'b0;
    repeat (3) step();
    check("midrst edge3", 16'(LEDR), 16'h0000);
    step();
    check("midrst edge4", 16'(LEDR), 16'h0155);

    // ---------- boundary: all zeros then all ones ----------
    RST = 1'b1;
    step();
    SW  = 10'h000;
    RST = 1'b0;
    repeat (15) step();
    check("bound 000", 16'(LEDR), 16'h0000);
    SW = 10'h3FF;
    repeat (8) step();
    check("bound 3FF", 16'(LEDR), 16'h03FF);
    check("bound r1 full", dut.regs_q[1], 16'h03FF);
    check("bound r1 upper", 16'(dut.regs_q[1][15:10]), 16'h0000);

    // ---------- random traffic against the model ----------
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 49) == 0) RST = 1'b1;
      else RST = 1'b0;
      if ($urandom_range(0, 6) == 0) SW = 10'($urandom);
      step();
      check($sformatf("rand[%0d] LEDR", c), 16'(LEDR), 16'(m_led));
    end
    RST = 1'b0;

    // Settle with constant SW: must converge.
    rsw = 10'($urandom);
    SW  = rsw;
    repeat (15) step();
    check("rand settle LEDR==SW", 16'(LEDR), 16'(rsw));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/minilab0_sw_led_core.md
Name: minilab0_sw_led_core

Overview:
- Minimal programmable I/O core for the board bring-up lab.
- A tiny two-phase (fetch/execute) sequencer runs a fixed program from internal ROM. The program repeatedly reads the 10 slide switches through an input port and writes them to the 10 LEDs through an output port.
- Top-level block: connects straight to board clock, reset button logic, SW and LEDR.

Parameters:
- ROM_DEPTH, 16, number of 16-bit instruction words in the internal ROM; PC width is log2(ROM_DEPTH).
- SW_PORT, 8'h01, I/O port number mapped to switch input.
- LED_PORT, 8'h00, I/O port number mapped to LED output register.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- SW  input  10  slide-switch levels, sampled synchronously, no synchronizer.
- LEDR  output  10  LED drive, registered.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (RST=1 at a rising edge):
  - PC=0, state=FETCH, IR=0.
  - Registers r0..r3=16'h0000.
  - LEDR=10'h000.
  - Reset overrides everything, including mid-instruction; no partial write completes.
- State machine:
  - FETCH: IR <= ROM[PC]; PC <= PC+1 (wraps at ROM_DEPTH); next state EXEC.
  - EXEC: performs the IR operation; next state FETCH.
  - Each instruction takes exactly 2 cycles.
- Instruction format: [15:12] opcode, [11:10] rd/rs, [9:8] unused (0), [7:0] imm8/port/target.
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDI: rd <= {8'h00, imm8}.
  - 0x2 IN: rd <= {6'b0, SW} if imm8==SW_PORT, else 16'h0000.
  - 0x3 OUT: if imm8==LED_PORT, LEDR <= rs[9:0]; other ports are ignored, no effect.
  - 0x4 JMP: PC <= imm8 truncated to PC width; this overrides the increment from FETCH.
  - 0xF HALT: state stays in EXEC permanently (PC and registers frozen, LEDR held) until reset.
  - All other opcodes execute as NOP.
- Fixed ROM contents:
  - addr0: IN r1, SW_PORT.
  - addr1: OUT r1, LED_PORT.
  - addr2: JMP 0.
  - addr3..end: NOP.
- Timing after the first rising edge with RST=0 (edge 1):
  - Edge 2 captures SW into r1.
  - Edge 4 updates LEDR with that value.
  - Loop period is 6 cycles.
  - Steady state: any SW change appears on LEDR no later than 8 rising edges after it is stable.
  - LEDR must equal SW within 15 cycles of reset release, as long as SW is held constant.
- SW is sampled at the EXEC edge of IN. LEDR changes only on the EXEC edge of OUT and holds between writes.
- Register r0 is an ordinary register, not hardwired zero. Reads of unwritten registers return 0.
- No bus handshakes; the core is always running when not in reset or HALT.

Test Plan:
- Reset: hold RST=1 for 2 cycles with SW=10'h3FF -> LEDR=10'h000, PC=0, state=FETCH.
- Release with SW=10'h2A5 -> LEDR=10'h000 through edge 3; LEDR=10'h2A5 at edge 4 and held through edge 15.
- Ten loops of: assert RST for 1 cycle, set a random SW, release, wait 15 edges -> LEDR==SW each time; zero mismatches.
- Live tracking: after steady state, change SW from 10'h001 to 10'h200 -> LEDR=10'h200 within 8 edges; no intermediate values other than 10'h001 or 10'h200.
- Reset mid-instruction: assert RST at the EXEC edge of OUT with SW=10'h155 while LEDR=10'h0F0 -> LEDR=10'h000 (the OUT does not complete). After release, LEDR=10'h155 at edge 4.
- Wrap/boundary: SW=10'h000, then 10'h3FF -> LEDR follows exactly, with all 10 bits driven. The upper bits of r1 stay 0, checked via a hierarchical probe.
